// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// counter sizing helpers and the millisecond-to-cycle conversion.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input longint value);
    longint v;
    int     w;
    v = value - 1;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

  // Bits needed to hold every count from 0 up to and including value.
  function automatic int cnt_width(input longint value);
    int w;
    w = clog2(value + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cycles_for_ms(input longint clk_freq, input longint ms);
    return int'(clk_freq / 1000 * ms);
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounced button: 2-flop synchroniser, press/release debounce FSM,
// hold timer and registered press/release/long-press pulses.
module button_debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int C_DB_CYC = 10,
  parameter int C_LP_CYC = 1000
) (
  input  logic clk,
  input  logic aresetn,
  input  logic button_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DB_W   = cnt_width(C_DB_CYC);
  localparam int HOLD_W = cnt_width(C_LP_CYC);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(C_DB_CYC - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(C_LP_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(C_LP_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [1:0]        sync_reg;
  logic              sample;
  btn_state_e        state_reg, state_next;
  logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              level_reg, level_next;
  logic              press_reg, press_next;
  logic              release_reg, release_next;
  logic              long_reg, long_next;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], button_in};
    end
  end

  assign sample = sync_reg[1];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= RELEASED;
      db_cnt_reg   <= '0;
      hold_cnt_reg <= '0;
      level_reg    <= 1'b0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      long_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      db_cnt_reg   <= db_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      level_reg    <= level_next;
      press_reg    <= press_next;
      release_reg  <= release_next;
      long_reg     <= long_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    db_cnt_next   = db_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    level_next    = level_reg;
    press_next    = 1'b0;
    release_next  = 1'b0;
    long_next     = 1'b0;

    // The hold timer keeps running through a pending release so that a
    // release completing on the long-press edge still reports both pulses.
    if ((state_reg == PRESSED || state_reg == RELEASE_WAIT) && hold_cnt_reg != HOLD_MAX) begin
      hold_cnt_next = hold_cnt_reg + HOLD_ONE;
      long_next     = (hold_cnt_reg == HOLD_LAST);
    end

    case (state_reg)
      RELEASED: begin
        level_next = 1'b0;
        if (sample) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = DB_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sample) begin
          state_next  = RELEASED;
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next    = PRESSED;
          level_next    = 1'b1;
          press_next    = 1'b1;
          db_cnt_next   = '0;
          hold_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt_reg + DB_ONE;
        end
      end
      PRESSED: begin
        level_next = 1'b1;
        if (!sample) begin
          state_next  = RELEASE_WAIT;
          db_cnt_next = DB_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (sample) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next   = RELEASED;
          level_next   = 1'b0;
          release_next = 1'b1;
          db_cnt_next  = '0;
        end else begin
          db_cnt_next = db_cnt_reg + DB_ONE;
        end
      end
      default: begin
        state_next  = RELEASED;
        level_next  = 1'b0;
        db_cnt_next = '0;
      end
    endcase
  end

  assign level         = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_pulse    = long_reg;

endmodule

// File: rtl/button_debouncer.sv
// Bank of independent debounced push-buttons with press, release and
// long-press pulses; optional input inversion for active-low pins.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int C_NUM_BUTTONS   = 3,
  parameter int C_CLK_FREQ      = 100000000,
  parameter int C_DEBOUNCE_MS   = 10,
  parameter int C_LONG_PRESS_MS = 1000,
  parameter int C_ACTIVE_LOW    = 0
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [C_NUM_BUTTONS-1:0] buttons_raw,
  output logic [C_NUM_BUTTONS-1:0] buttons_level,
  output logic [C_NUM_BUTTONS-1:0] buttons_press,
  output logic [C_NUM_BUTTONS-1:0] buttons_release,
  output logic [C_NUM_BUTTONS-1:0] buttons_long
);

  localparam int DB_CYC = cycles_for_ms(C_CLK_FREQ, C_DEBOUNCE_MS);
  localparam int LP_CYC = cycles_for_ms(C_CLK_FREQ, C_LONG_PRESS_MS);

  // The debounce FSM needs at least one counting cycle between entry and accept.
  if (DB_CYC < 2) begin : g_db_cyc_check
    $error("button_debouncer: debounce time must be at least 2 clock cycles");
  end

  logic [C_NUM_BUTTONS-1:0] buttons_in;

  // Inside the channels 1 always means pressed.
  assign buttons_in = (C_ACTIVE_LOW != 0) ? ~buttons_raw : buttons_raw;

  for (genvar gi = 0; gi < C_NUM_BUTTONS; gi++) begin : g_channel
    button_debounce_channel #(
      .C_DB_CYC (DB_CYC),
      .C_LP_CYC (LP_CYC)
    ) u_channel (
      .clk           (clk),
      .aresetn       (aresetn),
      .button_in     (buttons_in[gi]),
      .level         (buttons_level[gi]),
      .press_pulse   (buttons_press[gi]),
      .release_pulse (buttons_release[gi]),
      .long_pulse    (buttons_long[gi])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench: an active-high and an active-low instance driven with
// complementary pins, both compared every cycle against a run-length model.
module tb_button_debouncer;

  localparam int N  = 3;
  localparam int DB = 10;
  localparam int LP = 1000;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [N-1:0] raw;
  logic [N-1:0] raw_n;
  logic [N-1:0] lvl_h, prs_h, rel_h, lng_h;
  logic [N-1:0] lvl_l, prs_l, rel_l, lng_l;

  always #5 clk = ~clk;
  assign raw_n = ~raw;

  button_debouncer #(
    .C_NUM_BUTTONS(N), .C_CLK_FREQ(1000), .C_DEBOUNCE_MS(10),
    .C_LONG_PRESS_MS(1000), .C_ACTIVE_LOW(0)
  ) dut_hi (
    .clk(clk), .aresetn(aresetn), .buttons_raw(raw),
    .buttons_level(lvl_h), .buttons_press(prs_h),
    .buttons_release(rel_h), .buttons_long(lng_h)
  );

  button_debouncer #(
    .C_NUM_BUTTONS(N), .C_CLK_FREQ(1000), .C_DEBOUNCE_MS(10),
    .C_LONG_PRESS_MS(1000), .C_ACTIVE_LOW(1)
  ) dut_lo (
    .clk(clk), .aresetn(aresetn), .buttons_raw(raw_n),
    .buttons_level(lvl_l), .buttons_press(prs_l),
    .buttons_release(rel_l), .buttons_long(lng_l)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: accepted level flips after DB consecutive sampled
  // disagreements; long fires when LP edges have elapsed since the press.
  logic [N-1:0] mq[$];
  logic [N-1:0] m_lvl, m_press, m_rel, m_long;
  int           m_run[N];
  int           m_held[N];

  int n_press[N], n_rel[N], n_long[N];

  typedef struct {
    logic [N-1:0] raw;
    int           cycles;
    logic [N-1:0] exp_level;
    int           exp_press;
    int           exp_rel;
    int           exp_long;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    mq.push_back('0);
    mq.push_back('0);
    m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
  endfunction

  function automatic void model_edge(input logic [N-1:0] r);
    logic [N-1:0] smp;
    smp = mq.pop_front();
    mq.push_back(r);
    m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      if (m_lvl[c]) begin
        m_held[c]++;
        if (m_held[c] == LP) m_long[c] = 1'b1;
      end
      if (smp[c] != m_lvl[c]) m_run[c]++;
      else m_run[c] = 0;
      if (m_run[c] == DB) begin
        m_run[c] = 0;
        m_lvl[c] = smp[c];
        if (smp[c]) begin
          m_press[c] = 1'b1;
          m_held[c]  = 0;
        end else begin
          m_rel[c] = 1'b1;
        end
      end
    end
  endfunction

  task automatic clear_counts();
    for (int c = 0; c < N; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
    end
  endtask

  function automatic int sum3(input int a[N]);
    return a[0] + a[1] + a[2];
  endfunction

  task automatic step(input logic [N-1:0] r);
    raw = r;
    @(posedge clk);
    if (aresetn) model_edge(r);
    else model_reset();
    #1;
    check("model_hi", {lvl_h, prs_h, rel_h, lng_h}, {m_lvl, m_press, m_rel, m_long});
    check("model_lo", {lvl_l, prs_l, rel_l, lng_l}, {m_lvl, m_press, m_rel, m_long});
    for (int c = 0; c < N; c++) begin
      n_press[c] += int'(prs_h[c]);
      n_rel[c]   += int'(rel_h[c]);
      n_long[c]  += int'(lng_h[c]);
    end
  endtask

  // kind: 0 press, 1 release, 2 long. n = edges until the pulse is seen.
  task automatic wait_pulse(input string name, input int kind, input int ch,
                            input logic [N-1:0] r, input int budget, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      step(r);
      n++;
      case (kind)
        0:       found = prs_h[ch];
        1:       found = rel_h[ch];
        default: found = lng_h[ch];
      endcase
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s no pulse within %0d cycles (want one)", name, budget);
    end
  endtask

  task automatic async_reset(input string name);
    #2;
    aresetn = 1'b0;
    #1;
    model_reset();
    check(name, {lvl_h, prs_h, rel_h, lng_h, lvl_l, prs_l, rel_l, lng_l}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [N-1:0] r;
    int len;

    tbl[0]  = '{3'b000, 20, 3'b000, 0, 0, 0};
    tbl[1]  = '{3'b001,  9, 3'b000, 0, 0, 0};
    tbl[2]  = '{3'b000, 15, 3'b000, 0, 0, 0};
    tbl[3]  = '{3'b101, 11, 3'b000, 0, 0, 0};
    tbl[4]  = '{3'b101,  1, 3'b101, 2, 0, 0};
    tbl[5]  = '{3'b000, 11, 3'b101, 0, 0, 0};
    tbl[6]  = '{3'b000,  1, 3'b000, 0, 2, 0};
    tbl[7]  = '{3'b010, 30, 3'b010, 1, 0, 0};
    tbl[8]  = '{3'b000, 12, 3'b000, 0, 1, 0};
    tbl[9]  = '{3'b111, 12, 3'b111, 3, 0, 0};
    tbl[10] = '{3'b000, 12, 3'b000, 0, 3, 0};

    aresetn = 1'b0;
    raw = '0;
    model_reset();
    clear_counts();

    // Buttons held through reset, then seen as a fresh press.
    for (int i = 0; i < 20; i++) step(3'b111);
    check("reset_outputs", {lvl_h, prs_h, rel_h, lng_h, lvl_l, prs_l, rel_l, lng_l}, 0);
    aresetn = 1'b1;
    wait_pulse("reset_press", 0, 0, 3'b111, 40, n);
    check("reset_press_edge", n, 12);
    check("reset_press_all", prs_h, 3'b111);
    check("reset_level_all", lvl_h, 3'b111);
    clear_counts();
    for (int i = 0; i < 15; i++) step(3'b000);
    check("reset_release_cnt", sum3(n_rel), 3);

    for (int i = 0; i < 11; i++) begin
      clear_counts();
      for (int k = 0; k < tbl[i].cycles; k++) step(tbl[i].raw);
      check($sformatf("vec%0d_level", i), lvl_h, tbl[i].exp_level);
      check($sformatf("vec%0d_press", i), sum3(n_press), tbl[i].exp_press);
      check($sformatf("vec%0d_release", i), sum3(n_rel), tbl[i].exp_rel);
      check($sformatf("vec%0d_long", i), sum3(n_long), tbl[i].exp_long);
    end

    // Bounce on button 1: 3-cycle runs never reach the debounce time.
    clear_counts();
    for (int i = 0; i < 30; i++) step(((i / 3) % 2 == 0) ? 3'b010 : 3'b000);
    check("bounce_no_press", n_press[1], 0);
    wait_pulse("bounce_press", 0, 1, 3'b010, 40, n);
    check("bounce_press_edge", n, 12);
    for (int i = 0; i < 20; i++) step(3'b010);
    check("bounce_press_once", n_press[1], 1);
    wait_pulse("bounce_release", 1, 1, 3'b000, 40, n);
    check("bounce_release_edge", n, 12);
    for (int i = 0; i < 20; i++) step(3'b000);
    check("bounce_release_once", n_rel[1], 1);

    // Long press on button 2 held 1500 cycles.
    clear_counts();
    wait_pulse("long_press", 0, 2, 3'b100, 40, n);
    check("long_press_edge", n, 12);
    wait_pulse("long_pulse", 2, 2, 3'b100, 1100, n);
    check("long_pulse_edge", n, LP);
    for (int i = 0; i < 488; i++) step(3'b100);
    check("long_once", n_long[2], 1);
    wait_pulse("long_release", 1, 2, 3'b000, 40, n);
    check("long_release_edge", n, 12);
    for (int i = 0; i < 20; i++) step(3'b000);
    check("long_once_after", n_long[2], 1);

    // Release completing exactly on the long-press edge reports both.
    wait_pulse("coinc_press", 0, 2, 3'b100, 40, n);
    for (int i = 0; i < 988; i++) step(3'b100);
    wait_pulse("coinc_release", 1, 2, 3'b000, 40, n);
    check("coinc_release_edge", n, 12);
    check("coinc_long", lng_h[2], 1'b1);
    for (int i = 0; i < 20; i++) step(3'b000);

    // Reset mid-debounce (count 5) and mid-hold (400 cycles).
    for (int i = 0; i < 7; i++) step(3'b001);
    async_reset("rst_mid_debounce");
    for (int i = 0; i < 3; i++) step(3'b001);
    aresetn = 1'b1;
    wait_pulse("rst_press1", 0, 0, 3'b001, 40, n);
    check("rst_press1_edge", n, 12);
    for (int i = 0; i < 400; i++) step(3'b001);
    check("rst_level_before", lvl_h[0], 1'b1);
    async_reset("rst_mid_hold");
    for (int i = 0; i < 3; i++) step(3'b001);
    aresetn = 1'b1;
    wait_pulse("rst_press2", 0, 0, 3'b001, 40, n);
    check("rst_press2_edge", n, 12);
    clear_counts();
    for (int i = 0; i < 700; i++) step(3'b001);
    check("rst_no_early_long", n_long[0], 0);
    wait_pulse("rst_long", 2, 0, 3'b001, 400, n);
    check("rst_long_edge", n, 300);
    for (int i = 0; i < 15; i++) step(3'b000);

    // Random segments, checked cycle by cycle against the model.
    for (int s = 0; s < 300; s++) begin
      r   = N'($urandom_range(0, 7));
      len = int'($urandom_range(1, 24));
      for (int k = 0; k < len; k++) step(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side conditioner for the board push-buttons that drive the LED group selector.
- Synchronises raw asynchronous button pins and removes contact bounce per button.
- Outputs clean levels, plus one-cycle press, release and long-press pulses, to LED-select and debug-control logic.
- One instance per button bank; each button is an independent channel.

Parameters:
- C_NUM_BUTTONS, 3, number of button channels.
- C_CLK_FREQ, 100000000, clk frequency in Hz.
- C_DEBOUNCE_MS, 10, stable time required before a change is accepted.
- C_LONG_PRESS_MS, 1000, held time after the accepted press that generates the long-press pulse.
- C_ACTIVE_LOW, 0, 1 = raw pins read 0 when pressed (inverted at input).

Ports:
- clk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- buttons_raw  in  C_NUM_BUTTONS  raw asynchronous button pins.
- buttons_level  out  C_NUM_BUTTONS  debounced level, 1 = pressed.
- buttons_press  out  C_NUM_BUTTONS  one-cycle pulse on accepted press.
- buttons_release  out  C_NUM_BUTTONS  one-cycle pulse on accepted release.
- buttons_long  out  C_NUM_BUTTONS  one-cycle pulse when held for the long-press time.

Behaviour:
- Reset and clock: reset aresetn, asynchronous, active-low; clock clk. All flops clear asynchronously.
- Reset values: all outputs 0; sync flops hold the not-pressed value; counters 0; every FSM in RELEASED.
- Derived constants:
  - DB_CYC = C_CLK_FREQ/1000*C_DEBOUNCE_MS
  - LP_CYC = C_CLK_FREQ/1000*C_LONG_PRESS_MS
  - Counter widths = clog2(value+1).
  - DB_CYC >= 2 is required; an elaboration-time check fails otherwise.
- Input path: optional inversion (C_ACTIVE_LOW), then a 2-flop synchroniser per bit. The output of the synchroniser is called "sample".
- Per-channel FSM (4 states):
  - RELEASED: level=0. sample=1 -> PRESS_WAIT, db_cnt<=1.
  - PRESS_WAIT:
    - sample=0 -> RELEASED, db_cnt<=0; the glitch is discarded and no pulse is produced.
    - sample=1 and db_cnt==DB_CYC-1 -> PRESSED, level<=1, press pulse, hold_cnt<=0.
    - Otherwise db_cnt++.
  - PRESSED: level=1.
    - hold_cnt increments each cycle and saturates at LP_CYC.
    - The long pulse is asserted on the single cycle hold_cnt transitions LP_CYC-1 -> LP_CYC. It never repeats.
    - sample=0 -> RELEASE_WAIT, db_cnt<=1.
  - RELEASE_WAIT: level stays 1 and hold_cnt keeps running.
    - sample=1 -> PRESSED, db_cnt<=0, with no pulse.
    - sample=0 and db_cnt==DB_CYC-1 -> RELEASED, level<=0, release pulse.
    - Otherwise db_cnt++.
- Latency: a clean raw edge, held stable, gives its level change and pulse DB_CYC+2 rising clk edges later (2 sync + DB_CYC debounce). The pulse and the level change are registered on the same edge.
- Pulse rule: press, release and long are registered outputs, high for exactly one cycle.
  - press and release of the same channel are never high together.
  - long and release may both be high in the same cycle only if the release completes exactly at the LP_CYC edge. Both are reported.
- Channels are independent. Simultaneous presses on several channels give simultaneous pulses.
- Button held through reset release: it is seen as a new press DB_CYC+2 cycles after deassertion.
- Reset asserted mid-debounce or mid-hold: everything clears immediately and no pulse is produced. Counting restarts after release.

Decomposition:
- Shared package/header holds:
  - FSM state encoding: RELEASED=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3.
  - clog2 function.
  - The DB_CYC/LP_CYC derivation.
- Sub-module button_debounce_channel contains sync, FSM, db_cnt, hold_cnt and the three pulse flops for one button. The top instantiates it C_NUM_BUTTONS times in a generate loop and handles the C_ACTIVE_LOW inversion.

Test Plan (bench uses C_CLK_FREQ=1000, C_DEBOUNCE_MS=10, C_LONG_PRESS_MS=1000, so DB_CYC=10 and LP_CYC=1000):
1. Reset: hold aresetn=0 with raw=3'b111 for 20 cycles -> all outputs 0. Release reset with raw still high -> press=3'b111 for one cycle and level=3'b111, both on edge 12 after deassertion.
2. Glitch: raw[0] high for 9 cycles, then low -> no press, level[0] stays 0, FSM returns to RELEASED.
3. Bounce: raw[1] toggles every 3 cycles for 30 cycles, then stays high -> exactly one press[1] pulse, 12 edges after the final edge. A later clean release gives exactly one release[1] pulse 12 edges after it.
4. Long press: raw[2] held 1500 cycles -> press[2] at edge 12 and long[2] exactly 1000 cycles after press[2], once only. release[2] comes 12 edges after raw falls.
5. Mixed and active-low:
   - Press buttons 0 and 2 in the same cycle -> simultaneous pulses; button 1 stays untouched.
   - Repeat with C_ACTIVE_LOW=1 and inverted stimulus -> identical outputs.
6. Reset mid-operation: assert aresetn at debounce count 5, then again 400 cycles into a hold -> outputs drop to 0 immediately, no spurious pulses. After release the timing restarts from zero.
